// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: decode-side inputs, datapath operands and forwarding/stall outputs of fwd_hazard_unit
interface fwd_hazard_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic              id_rs_used, id_rt_used;
   logic              id_regwrite, id_memread, id_memwrite;
   logic              flush;
   logic [DATA_W-1:0] ex_rs_data, ex_rt_data, mem_alu_data, wb_data, mem_store_data_in;
   logic              stall;
   logic [1:0]        fwd_a_sel, fwd_b_sel;
   logic [DATA_W-1:0] ex_op_a, ex_op_b;
   logic              fwd_mm;
   logic [DATA_W-1:0] mem_store_data;
   logic [CNT_W-1:0]  stall_cnt;
   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
             id_regwrite, id_memread, id_memwrite, flush,
             ex_rs_data, ex_rt_data, mem_alu_data, wb_data, mem_store_data_in,
      output stall, fwd_a_sel, fwd_b_sel, ex_op_a, ex_op_b, fwd_mm, mem_store_data, stall_cnt
   );
   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
             id_regwrite, id_memread, id_memwrite, flush,
             ex_rs_data, ex_rt_data, mem_alu_data, wb_data, mem_store_data_in,
      input  stall, fwd_a_sel, fwd_b_sel, ex_op_a, ex_op_b, fwd_mm, mem_store_data, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/MEM/WB scoreboard driving operand forwarding, MEM-MEM store forwarding and load-use stalls
// Define FWD_MEM_MEM_EN to resolve store-data load-use via MEM-MEM forwarding instead of stalling.
module fwd_hazard_unit #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input logic clk,
   input logic rst_n,
   fwd_hazard_if.slave bus
);
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs, rt, rd;
      logic              rs_used, rt_used, regwrite, memread, memwrite;
   } slot_t;
   slot_t id_s, ex_s, mem_s, wb_s;
   logic mem_prod, wb_prod, ex_load, rs_hit, rt_hit, hazard;
   logic a_mem, a_wb, b_mem, b_wb;
   assign id_s = {bus.id_valid, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_rs_used, bus.id_rt_used,
                  bus.id_regwrite, bus.id_memread, bus.id_memwrite};
   assign mem_prod = mem_s.valid & mem_s.regwrite & (mem_s.rd != '0);
   assign wb_prod  = wb_s.valid & wb_s.regwrite & (wb_s.rd != '0);
   assign a_mem = ex_s.valid & ex_s.rs_used & mem_prod & (mem_s.rd == ex_s.rs);
   assign a_wb  = ex_s.valid & ex_s.rs_used & wb_prod & (wb_s.rd == ex_s.rs);
   assign b_mem = ex_s.valid & ex_s.rt_used & mem_prod & (mem_s.rd == ex_s.rt);
   assign b_wb  = ex_s.valid & ex_s.rt_used & wb_prod & (wb_s.rd == ex_s.rt);
   assign bus.fwd_a_sel = a_mem ? 2'b10 : a_wb ? 2'b01 : 2'b00;
   assign bus.fwd_b_sel = b_mem ? 2'b10 : b_wb ? 2'b01 : 2'b00;
   assign bus.ex_op_a = a_mem ? bus.mem_alu_data : a_wb ? bus.wb_data : bus.ex_rs_data;
   assign bus.ex_op_b = b_mem ? bus.mem_alu_data : b_wb ? bus.wb_data : bus.ex_rt_data;
   assign ex_load = ex_s.valid & ex_s.regwrite & ex_s.memread & (ex_s.rd != '0);
   assign rs_hit  = ex_load & bus.id_rs_used & (bus.id_rs == ex_s.rd);
   assign rt_hit  = ex_load & bus.id_rt_used & (bus.id_rt == ex_s.rd);
`ifdef FWD_MEM_MEM_EN
   // store data can wait one more cycle: it is patched in MEM from WB
   assign hazard = rs_hit | (rt_hit & ~bus.id_memwrite);
   assign bus.fwd_mm = mem_s.valid & mem_s.memwrite & wb_prod & (wb_s.rd == mem_s.rt);
`else
   assign hazard = rs_hit | rt_hit;
   assign bus.fwd_mm = 1'b0;
`endif
   assign bus.mem_store_data = bus.fwd_mm ? bus.wb_data : bus.mem_store_data_in;
   assign bus.stall = bus.id_valid & hazard & ~bus.flush;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_s          <= '0;
         mem_s         <= '0;
         wb_s          <= '0;
         bus.stall_cnt <= '0;
      end else begin
         wb_s  <= mem_s;
         mem_s <= ex_s;
         ex_s  <= (bus.id_valid & ~bus.stall & ~bus.flush) ? id_s : '0;
         if (bus.stall & ~&bus.stall_cnt) bus.stall_cnt <= bus.stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random stimulus against an instruction-history model of the forwarding unit
module tb_fwd_hazard_unit;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int CW = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   fwd_hazard_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus();
   fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      bit v;
      int rs, rt, rd;
      bit ru, tu, rw, mr, mw;
   } ins_t;
   ins_t pipe[3];
   ins_t bub = '{v: 0, rs: 0, rt: 0, rd: 0, ru: 0, tu: 0, rw: 0, mr: 0, mw: 0};
   int ref_cnt = 0;
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t cur_id();
      ins_t t;
      t.v = bus.id_valid; t.rs = int'(bus.id_rs); t.rt = int'(bus.id_rt); t.rd = int'(bus.id_rd);
      t.ru = bus.id_rs_used; t.tu = bus.id_rt_used;
      t.rw = bus.id_regwrite; t.mr = bus.id_memread; t.mw = bus.id_memwrite;
      return t;
   endfunction

   // youngest older writer of r wins; pipe[1] is the MEM slot, pipe[2] the WB slot
   function automatic logic [1:0] ref_sel(input int r, input bit used);
      if (!pipe[0].v || !used) return 2'b00;
      for (int k = 1; k < 3; k++)
         if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == r) return (k == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic bit ref_stall();
      bit rs, rt;
      ins_t e = pipe[0];
      if (!(bus.id_valid && !bus.flush && e.v && e.rw && e.mr && e.rd != 0)) return 1'b0;
      rs = bus.id_rs_used && int'(bus.id_rs) == e.rd;
      rt = bus.id_rt_used && int'(bus.id_rt) == e.rd;
`ifdef FWD_MEM_MEM_EN
      return rs || (rt && !bus.id_memwrite);
`else
      return rs || rt;
`endif
   endfunction

   function automatic bit ref_mm();
`ifdef FWD_MEM_MEM_EN
      return pipe[1].v && pipe[1].mw && pipe[2].v && pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == pipe[1].rt;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] rf);
      return (s == 2'b10) ? bus.mem_alu_data : (s == 2'b01) ? bus.wb_data : rf;
   endfunction

   task automatic check_all();
      logic [1:0] sa, sb;
      sa = ref_sel(pipe[0].rs, pipe[0].ru);
      sb = ref_sel(pipe[0].rt, pipe[0].tu);
      chk("stall", 32'(bus.stall), 32'(ref_stall()));
      chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(sa));
      chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(sb));
      chk("ex_op_a", 32'(bus.ex_op_a), 32'(pick(sa, bus.ex_rs_data)));
      chk("ex_op_b", 32'(bus.ex_op_b), 32'(pick(sb, bus.ex_rt_data)));
      chk("fwd_mm", 32'(bus.fwd_mm), 32'(ref_mm()));
      chk("mem_store_data", 32'(bus.mem_store_data), 32'(ref_mm() ? bus.wb_data : bus.mem_store_data_in));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(ref_cnt));
   endtask

   task automatic probe();
      #1;
      check_all();
   endtask

   task automatic tick();
      bit st;
      ins_t nid;
      st = ref_stall();
      nid = cur_id();
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (nid.v && !st && !bus.flush) ? nid : bub;
      if (st && ref_cnt != (1 << CW) - 1) ref_cnt++;
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input int rs, input int rt, input int rd,
                         input bit ru, input bit tu, input bit rw, input bit mr, input bit mw);
      bus.id_valid = v; bus.id_rs = AW'(rs); bus.id_rt = AW'(rt); bus.id_rd = AW'(rd);
      bus.id_rs_used = ru; bus.id_rt_used = tu;
      bus.id_regwrite = rw; bus.id_memread = mr; bus.id_memwrite = mw;
      bus.flush = 1'b0;
   endtask

   task automatic set_data(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m,
                           input logic [DW-1:0] w, input logic [DW-1:0] s);
      bus.ex_rs_data = a; bus.ex_rt_data = b; bus.mem_alu_data = m; bus.wb_data = w; bus.mem_store_data_in = s;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      pipe[0] = bub; pipe[1] = bub; pipe[2] = bub;
      ref_cnt = 0;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      pipe[0] = bub; pipe[1] = bub; pipe[2] = bub;
      nop();
      set_data(16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d, 16'h0e0e);
      @(negedge clk);
      do_reset();
      // ADD r3 then SUB r4,r3,r2
      set_id(1, 1, 2, 3, 1, 1, 1, 0, 0); probe(); tick();
      set_id(1, 3, 2, 4, 1, 1, 1, 0, 0); probe(); tick();
      nop(); set_data(16'h0001, 16'h0002, 16'h1234, 16'h5555, 16'h0000);
      probe();
      chk("add_sub_sel_a", 32'(bus.fwd_a_sel), 32'h2);
      chk("add_sub_op_a", 32'(bus.ex_op_a), 32'h1234);
      tick();
      // r3 written twice, then read via rt
      set_id(1, 1, 1, 3, 1, 1, 1, 0, 0); probe(); tick();
      set_id(1, 2, 2, 3, 1, 1, 1, 0, 0); probe(); tick();
      set_id(1, 1, 3, 7, 1, 1, 1, 0, 0); probe(); tick();
      nop(); set_data(16'h0001, 16'h0002, 16'h2222, 16'h1111, 16'h0000);
      probe();
      chk("younger_sel_b", 32'(bus.fwd_b_sel), 32'h2);
      chk("younger_op_b", 32'(bus.ex_op_b), 32'h2222);
      tick();
      // LW r5 then ADD r6,r5,r1
      set_id(1, 1, 0, 5, 1, 0, 1, 1, 0); probe(); tick();
      set_id(1, 5, 1, 6, 1, 1, 1, 0, 0); probe();
      chk("load_use_stall", 32'(bus.stall), 32'h1);
      tick();
      probe();
      chk("load_use_release", 32'(bus.stall), 32'h0);
      tick();
      nop(); probe();
      chk("load_use_sel_a", 32'(bus.fwd_a_sel), 32'h1);
      chk("load_use_cnt", 32'(bus.stall_cnt), 32'h1);
      tick();
      // LW r5 then SW r5 as store data
      set_id(1, 1, 0, 5, 1, 0, 1, 1, 0); probe(); tick();
      set_data(16'h0001, 16'h0002, 16'h3333, 16'hbeef, 16'h0bad);
      set_id(1, 2, 5, 0, 1, 1, 0, 0, 1); probe();
`ifdef FWD_MEM_MEM_EN
      chk("store_no_stall", 32'(bus.stall), 32'h0);
      tick();
      nop(); probe(); tick();
      probe();
      chk("store_fwd_mm", 32'(bus.fwd_mm), 32'h1);
      chk("store_data_mm", 32'(bus.mem_store_data), 32'hbeef);
      tick();
`else
      chk("store_stall", 32'(bus.stall), 32'h1);
      tick();
      probe();
      chk("store_release", 32'(bus.stall), 32'h0);
      tick();
      nop(); probe(); tick();
      probe();
      chk("store_no_mm", 32'(bus.fwd_mm), 32'h0);
      chk("store_data_raw", 32'(bus.mem_store_data), 32'h0bad);
      tick();
`endif
      // LW r5 with dependent in ID and flush
      nop(); probe(); tick();
      set_id(1, 1, 0, 5, 1, 0, 1, 1, 0); probe(); tick();
      set_id(1, 5, 5, 6, 1, 1, 1, 0, 0); bus.flush = 1'b1; probe();
      chk("flush_no_stall", 32'(bus.stall), 32'h0);
      tick();
      bus.flush = 1'b0; probe();
      chk("flush_bubble", 32'(bus.stall), 32'h0);
      tick();
      // register 0 never forwards or stalls
      set_id(1, 1, 2, 0, 1, 1, 1, 1, 0); probe(); tick();
      set_id(1, 0, 0, 4, 1, 1, 1, 0, 0); probe();
      chk("r0_no_stall", 32'(bus.stall), 32'h0);
      tick();
      nop(); probe();
      chk("r0_sel_a", 32'(bus.fwd_a_sel), 32'h0);
      chk("r0_sel_b", 32'(bus.fwd_b_sel), 32'h0);
      tick();
      // mid-stream reset with a load in EX and a dependent in ID
      set_id(1, 1, 0, 9, 1, 0, 1, 1, 0); probe(); tick();
      set_id(1, 9, 9, 2, 1, 1, 1, 0, 0);
      do_reset();
      chk("reset_stall", 32'(bus.stall), 32'h0);
      chk("reset_cnt", 32'(bus.stall_cnt), 32'h0);
      probe(); tick();
      // random traffic
      for (int i = 0; i < 600; i++) begin
         set_data(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
         set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
         bus.flush = $urandom_range(0, 7) == 0;
         if ($urandom_range(0, 59) == 0) do_reset();
         probe();
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
